// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared FSM state encoding for the digit-serial adder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_digit_adder.sv
// ============================================================================
// Module      : digit_adder
// Description : Combinational DIGIT-bit ripple adder exposing carry-out and
//               the carry into its top bit (for signed overflow detection).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ctop
);

  always_comb begin
    logic w_c;
    w_c    = i_cin;
    o_sum  = '0;
    o_ctop = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) o_ctop = w_c;
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Digit-serial add/subtract, DIGIT bits per cycle, valid/ready
//               handshakes. Optional macro SERIAL_ADDER_OVF_EN adds port ovf.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
      $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             w_last;
  int               w_idx;
  logic [DIGIT-1:0] w_dsum;
  logic             w_dcout;
  logic             w_ctop;

  assign w_idx  = int'(r_cnt) * DIGIT;
  assign w_last = (r_cnt == CW'(NDIG - 1));

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .i_a    (r_a[w_idx +: DIGIT]),
    .i_b    (r_b[w_idx +: DIGIT]),
    .i_cin  (r_carry),
    .o_sum  (w_dsum),
    .o_cout (w_dcout),
    .o_ctop (w_ctop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Subtraction reuses the adder: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sum[w_idx +: DIGIT] <= w_dsum;
          r_carry               <= w_dcout;
          r_cnt                 <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_carry;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n)                         r_ovf <= 1'b0;
    else if ((r_state == S_RUN) && w_last) r_ovf <= w_ctop ^ w_dcout;
  end

  assign ovf = r_ovf;
`else
  logic w_unused_ctop;
  assign w_unused_ctop = w_ctop;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (16/4 and 8/8).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout;
  logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
  logic [7:0]  d8_a, d8_b, d8_sum;
  logic        d8_cin, d8_sub, d8_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf, d8_ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .a(d8_a), .b(d8_b), .cin(d8_cin), .sub(d8_sub), .out_valid(d8_out_valid),
    .out_ready(d8_out_ready), .sum(d8_sum), .cout(d8_cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(d8_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operation for a single cycle and counts cycles until out_valid.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic icin, input logic isub, output int lat);
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    d8_in_valid = 1'b0; d8_out_ready = 1'b0;
    d8_a = '0; d8_b = '0; d8_cin = 1'b0; d8_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (sum !== 16'h0000) begin n_errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL add_in_ready: got %b expected 1", in_ready); end
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
    n_checks++; if (sum !== 16'h5555) begin n_errors++; $display("FAIL add_sum: got %h expected 5555", sum); end
    n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL add_cout: got %b expected 0", cout); end
    release_result();
    issue(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, lat);
    n_checks++; if (sum !== 16'hFFFF || cout !== 1'b0) begin n_errors++; $display("FAIL add_alt: got %h/%b expected ffff/0", sum, cout); end
    release_result();
  endtask

  task automatic test_carry();
    int lat;
    issue(16'hFFFF, 16'h0001, 1'b1, 1'b0, lat);
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL carry_latency: got %0d expected 4", lat); end
    n_checks++; if (sum !== 16'h0001) begin n_errors++; $display("FAIL carry_sum: got %h expected 0001", sum); end
    n_checks++; if (cout !== 1'b1) begin n_errors++; $display("FAIL carry_cout: got %b expected 1", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL carry_ovf: got %b expected 0", ovf); end
`endif
    release_result();
  endtask

  task automatic test_sub();
    int lat;
    issue(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, lat);
    n_checks++; if (sum !== 16'h8000) begin n_errors++; $display("FAIL sub_sum: got %h expected 8000", sum); end
    n_checks++; if (cout !== 1'b0) begin n_errors++; $display("FAIL sub_cout: got %b expected 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
    n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL sub_ovf: got %b expected 1", ovf); end
`endif
    release_result();
    // cin must be ignored when subtracting
    issue(16'h0005, 16'h0003, 1'b1, 1'b1, lat);
    n_checks++; if (sum !== 16'h0002 || cout !== 1'b1) begin n_errors++; $display("FAIL sub_small: got %h/%b expected 0002/1", sum, cout); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(16'h1111, 16'h2222, 1'b1, 1'b0, lat);
    a = 16'hDEAD; b = 16'hBEEF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h3334 || cout !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_%0d: got v=%b r=%b sum=%h c=%b expected v=1 r=0 sum=3334 c=0", i, out_valid, in_ready, sum, cout);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    release_result();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL hold_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen = 0;
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++; if (in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0) begin n_errors++; $display("FAIL abort_state: got r=%b sum=%h c=%b expected r=1 sum=0000 c=0", in_ready, sum, cout); end
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
    issue(16'h0001, 16'h0002, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 4 || sum !== 16'h0003) begin n_errors++; $display("FAIL abort_next: got lat=%0d sum=%h expected lat=4 sum=0003", lat, sum); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 4 || sum !== 16'h0100) begin n_errors++; $display("FAIL b2b_first: got lat=%0d sum=%h expected lat=4 sum=0100", lat, sum); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_idle: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 4 || sum !== 16'h0000 || cout !== 1'b1) begin n_errors++; $display("FAIL b2b_second: got lat=%0d sum=%h c=%b expected lat=4 sum=0000 c=1", lat, sum, cout); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_full_digit();
    int lat = 0;
    d8_a = 8'h80; d8_b = 8'h80; d8_cin = 1'b0; d8_sub = 1'b0; d8_in_valid = 1'b1;
    @(posedge clk); #1;
    d8_in_valid = 1'b0;
    while (!d8_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL w8_latency: got %0d expected 1", lat); end
    n_checks++; if (d8_sum !== 8'h00 || d8_cout !== 1'b1) begin n_errors++; $display("FAIL w8_result: got %h/%b expected 00/1", d8_sum, d8_cout); end
`ifdef SERIAL_ADDER_OVF_EN
    n_checks++; if (d8_ovf !== 1'b1) begin n_errors++; $display("FAIL w8_ovf: got %b expected 1", d8_ovf); end
`endif
    d8_out_ready = 1'b1;
    @(posedge clk); #1;
    d8_out_ready = 1'b0;
    n_checks++; if (d8_out_valid !== 1'b0 || d8_in_ready !== 1'b1) begin n_errors++; $display("FAIL w8_release: got v=%b r=%b expected v=0 r=1", d8_out_valid, d8_in_ready); end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_add();
    test_carry();
    test_sub();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_full_digit();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
